// File: rtl/ovl_frame_multi.sv
// Multi-channel frame checker: per channel, a start rise opens a window in which
// test_expr must stay low for min_cks cycles and must rise within max_cks cycles.
module ovl_frame_multi #(
    parameter int    severity_level      = 1,
    parameter int    num_channels        = 4,
    parameter int    min_cks             = 0,
    parameter int    max_cks             = 0,
    parameter int    action_on_new_start = 0,
    parameter int    property_type       = 0,
    parameter string msg                 = "VIOLATION",
    parameter int    coverage_level      = 2,
    parameter int    cnt_width           = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [num_channels-1:0] start_event,
    input  logic [num_channels-1:0] test_expr,
    output logic [2:0]              fire,
    output logic [num_channels-1:0] fire_chan,
    output logic [num_channels-1:0] window_active,
    output logic [cnt_width-1:0]    viol_count
);

    localparam int unsigned lim = (min_cks > max_cks) ? min_cks : max_cks;
    localparam int unsigned cw  = (lim < 1) ? 1 : $clog2(lim + 1);
    localparam int unsigned pw  = $clog2(num_channels + 1);
    localparam int unsigned sw  = cnt_width + pw;

    localparam bit zero_win = (min_cks == 0) && (max_cks == 0);
    localparam bit fire_on  = (property_type != 2);
    localparam bit cov_on   = ((coverage_level & 2) != 0);
    localparam bit cfg_ok   = (action_on_new_start >= 0) && (action_on_new_start <= 2)
                            && !((max_cks > 0) && (min_cks > max_cks))
                            && (num_channels >= 1);

    localparam logic [cnt_width-1:0] cnt_max = '1;

    // Illegal configurations are reported once at elaboration; the checker then stays silent.
    if (!cfg_ok) begin : g_cfg_err
        if (severity_level == 0) begin : g_fatal
            $fatal(1, "%s: ovl_frame_multi illegal parameter configuration", msg);
        end else begin : g_error
            $error("%s: ovl_frame_multi illegal parameter configuration", msg);
        end
    end

    typedef enum logic {
        IDLE = 1'b0,
        OPEN = 1'b1
    } state_t;

    state_t                  state   [num_channels];
    state_t                  state_n [num_channels];
    logic [cw-1:0]           cnt     [num_channels];
    logic [cw-1:0]           cnt_n   [num_channels];
    logic [num_channels-1:0] start_q;
    logic [num_channels-1:0] rise;
    logic [num_channels-1:0] closing;
    logic [num_channels-1:0] viol_n;
    logic [num_channels-1:0] open_n;
    logic [num_channels-1:0] active_n;
    logic [num_channels-1:0] fire_vec;
    logic [pw-1:0]           pop_n;
    logic [sw-1:0]           sum_n;
    logic [cnt_width-1:0]    count_n;
    logic                    x_n;
    logic                    fire_any;
    logic                    fire_x;
    logic                    fire_cov;

    assign rise = start_event & ~start_q;

    // Per-channel window FSM: counter value equals the current window cycle, saturating at lim.
    always_comb begin
        closing = '0;
        viol_n  = '0;
        open_n  = '0;
        for (int c = 0; c < num_channels; c++) begin
            state_n[c] = state[c];
            cnt_n[c]   = cnt[c];
            if (!enable || !cfg_ok) begin
                state_n[c] = IDLE;
                cnt_n[c]   = '0;
            end else begin
                case (state[c])
                    IDLE: begin
                        if (rise[c]) begin
                            if (zero_win) begin
                                viol_n[c] = ~test_expr[c];
                            end else begin
                                state_n[c] = OPEN;
                                cnt_n[c]   = cw'(1);
                                open_n[c]  = 1'b1;
                            end
                        end
                    end
                    OPEN: begin
                        if (test_expr[c]) begin
                            closing[c] = 1'b1;
                            viol_n[c]  = (32'(cnt[c]) < min_cks);
                        end else if ((max_cks > 0) && (32'(cnt[c]) >= max_cks)) begin
                            closing[c] = 1'b1;
                            viol_n[c]  = 1'b1;
                        end
                        cnt_n[c] = (32'(cnt[c]) >= lim) ? cw'(lim) : cnt[c] + cw'(1);
                        if (closing[c]) begin
                            state_n[c] = IDLE;
                        end
                        // A closing window is resolved first, so a coincident start is a fresh open.
                        if (rise[c] && (action_on_new_start != 0)) begin
                            state_n[c] = OPEN;
                            cnt_n[c]   = cw'(1);
                            if (closing[c]) begin
                                open_n[c] = 1'b1;
                            end else if (action_on_new_start == 2) begin
                                viol_n[c] = 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    // Output-side next values: gated fires, window flags, saturating violation total.
    always_comb begin
        fire_vec = fire_on ? viol_n : '0;
        pop_n    = '0;
        for (int c = 0; c < num_channels; c++) begin
            active_n[c] = (state_n[c] == OPEN);
            pop_n       = pop_n + pw'(fire_vec[c]);
        end
        sum_n   = sw'(viol_count) + sw'(pop_n);
        count_n = (sum_n > sw'(cnt_max)) ? cnt_max : sum_n[cnt_width-1:0];
        x_n     = enable & ($isunknown(start_event) | $isunknown(test_expr));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            start_q <= '0;
            for (int c = 0; c < num_channels; c++) begin
                state[c] <= IDLE;
                cnt[c]   <= '0;
            end
        end else begin
            start_q <= enable ? start_event : '0;
            for (int c = 0; c < num_channels; c++) begin
                state[c] <= state_n[c];
                cnt[c]   <= cnt_n[c];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fire_chan     <= '0;
            window_active <= '0;
            viol_count    <= '0;
            fire_any      <= 1'b0;
            fire_x        <= 1'b0;
            fire_cov      <= 1'b0;
        end else begin
            fire_chan     <= fire_vec;
            window_active <= active_n;
            viol_count    <= count_n;
            fire_any      <= |fire_vec;
            fire_x        <= x_n;
            fire_cov      <= cov_on & (|open_n);
        end
    end

    assign fire = {fire_cov, fire_x, fire_any};

endmodule

// File: doc/ovl_frame_multi.md
Name: ovl_frame_multi

Overview:
- Multi-channel successor to the single-channel frame checker.
- For each of NUM_CHANNELS independent channels, a rising edge on start_event opens a window; test_expr must stay low for the first min_cks cycles and must rise within max_cks cycles.
- Adds per-channel fire/active outputs, saturating per-channel window counters, an error-and-restart mode for new starts, and an aggregate violation counter for regression reporting.
- Sits in the OVL checker library alongside the other ovl_* checkers and is bound next to the design logic it monitors.

Parameters:
- severity_level, 1, OVL severity passed to the simulation error report (0 fatal stops simulation).
- num_channels, 4, independent checker channels; must be 1 or more.
- min_cks, 0, minimum cycles before test_expr may rise; 0 disables the min check.
- max_cks, 0, maximum cycles by which test_expr must rise; 0 disables the max check.
- action_on_new_start, 0, behaviour on start while a window is open: 0 ignore, 1 restart, 2 error then restart.
- property_type, 0, 0 assert (fires), 1 assume (fires), 2 ignore (fire[0] and fire_chan forced 0).
- msg, "VIOLATION", text prefix for simulation reports.
- coverage_level, 2, coverage bitmask; bit1 (BASIC) enables fire[2].
- cnt_width, 8, width of the violation counter.

Ports:
- clock  input  1  checker clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  when low, all channels are forced to IDLE and no fire is produced.
- start_event  input  num_channels  per-channel start; the rising edge is detected per bit.
- test_expr  input  num_channels  per-channel expression under check.
- fire  output  3  bit0 any-channel violation, bit1 X-check, bit2 coverage (window opened).
- fire_chan  output  num_channels  per-channel violation pulse.
- window_active  output  num_channels  per-channel window-open flag.
- viol_count  output  cnt_width  total violations since reset; saturates at all-ones.

Behaviour:
- Reset: synchronous and active-high; while reset=1 at an edge, every channel goes to IDLE and fire, fire_chan, window_active and viol_count all become 0.
- Sampled start register: reset to 0. It is updated every cycle when enable=1 and cleared when enable=0, so the first start after enable rises is always seen as an edge.
- Start rise on channel c: start_event[c]=1 at edge k and the sampled copy was 0 at edge k-1. Edge k is window cycle 0.
- Per-channel states:
  - IDLE to OPEN on a start rise. The counter is set to 1 at the next edge.
  - OPEN: the counter increments each edge and saturates at max(min_cks, max_cks).
  - OPEN to IDLE when test_expr=1 and counter is at least min_cks (pass, no fire).
- Min violation: test_expr=1 at window cycle j, 1 ≤ j < min_cks. This fires and returns the channel to IDLE.
- Max violation (max_cks>0): test_expr=0 at every cycle 1..max_cks. This fires at edge k+max_cks and returns the channel to IDLE.
- Zero window (min_cks=0 and max_cks=0): test_expr is checked at cycle 0 itself. If it is 0, the channel fires; the channel stays in IDLE either way.
- Start rise while OPEN:
  - Mode 0: ignored.
  - Mode 1: counter restarts; the edge becomes the new cycle 0.
  - Mode 2: fires, then restarts.
  - If a pass and a restart occur on the same edge, the pass is taken first and the new window then opens.
- Fire timing: all outputs are registered. fire_chan[c] is a 1-cycle pulse in the cycle after the violating edge. fire[0] is the OR of fire_chan.
- viol_count adds popcount(fire_chan) each cycle and saturates without wrapping.
- fire[2] pulses one cycle after any IDLE-to-OPEN transition, only when coverage bit1 is set.
- fire[1]: simulation-only. It pulses when enable=1 and start_event or test_expr contains X/Z. Synthesized as constant 0.
- window_active[c]=1 exactly while channel c is OPEN.
- Reset or enable=0 in mid-window aborts silently, with no fire.
- Initial configuration errors are reported through the OVL error task, with no fire:
  - action_on_new_start greater than 2;
  - max_cks>0 and min_cks>max_cks;
  - num_channels<1.

Test Plan:
- min=2, max=5, ch0 start at edge 10, test_expr at edge 13 -> pass; no fire; window_active[0] high from edge 10 to edge 13.
- min=2, max=5, ch1 start at edge 10, test_expr at edge 11 -> fire_chan=4'b0010 and fire[0]=1 for the cycle after edge 11; viol_count=1.
- max=3, ch2 start at edge 20, test_expr held 0 -> fire_chan[2] pulses after edge 23; window_active[2] low after edge 23.
- Mode 2, ch0 restarts at edge 12 inside a window opened at edge 10 -> fire pulse after edge 12; the new window expires at 12+max_cks.
- Channels 0 and 3 violate on the same edge with viol_count=254 and cnt_width=8 -> fire_chan=4'b1001; viol_count saturates at 255.
- Reset=1 at edge 15 mid-window -> all outputs 0 after edge 15; no fire; a start at edge 17 opens a fresh window.
